// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised dual-port RAM family.
// be_merge is used by the array write path and by the write-first collision bypass.
package ram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } coll_mode_e;

  localparam int MAX_RD_LAT = 3;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  // Bytes not enabled keep the old value only if the entry was already initialised.
  function automatic logic [MAX_DATA_W-1:0] be_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be,
    input logic                  init
  );
    logic [MAX_DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i])
        res[8*i +: 8] = new_word[8*i +: 8];
      else if (init)
        res[8*i +: 8] = old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result delay line: RD_LAT register stages carrying {valid, data, uninit, err}.
// Data only advances with a valid beat, so the final stage holds the last returned word.
module ram_rd_pipe
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_uninit,
  input  logic              s0_err,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_uninit,
  output logic              rd_err
);

  logic              v_q [RD_LAT];
  logic [DATA_W-1:0] d_q [RD_LAT];
  logic              u_q [RD_LAT];
  logic              e_q [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RD_LAT; k++) begin
        v_q[k] <= 1'b0;
        d_q[k] <= '0;
        u_q[k] <= 1'b0;
        e_q[k] <= 1'b0;
      end
    end else begin
      v_q[0] <= s0_valid;
      u_q[0] <= s0_valid & s0_uninit;
      e_q[0] <= s0_valid & s0_err;
      if (s0_valid)
        d_q[0] <= s0_data;
      for (int k = 1; k < RD_LAT; k++) begin
        v_q[k] <= v_q[k-1];
        u_q[k] <= u_q[k-1];
        e_q[k] <= e_q[k-1];
        if (v_q[k-1])
          d_q[k] <= d_q[k-1];
      end
    end
  end

  assign rd_valid  = v_q[RD_LAT-1];
  assign rd_data   = d_q[RD_LAT-1];
  assign rd_uninit = u_q[RD_LAT-1];
  assign rd_err    = e_q[RD_LAT-1];

endmodule

// File: rtl/ram_dp_param.sv
// Simple dual-port synchronous RAM with byte enables, init tracking, range errors
// and a selectable same-address read/write collision mode.
module ram_dp_param
  import ram_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         ADDR_W    = 4,
  parameter int         DEPTH     = 16,
  parameter int         RD_LAT    = 1,
  parameter coll_mode_e COLL_MODE = WRITE_FIRST,
  localparam int        BE_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enb,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_enb,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_uninit,
  output logic              rd_err,
  output logic              wr_err
);

  if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
    $fatal(1, "ram_dp_param: DATA_W must be a non-zero multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $fatal(1, "ram_dp_param: RD_LAT must be within 1..3");
  end
  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $fatal(1, "ram_dp_param: DEPTH must be within 2..2**ADDR_W");
  end

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  init_q;

  logic              wr_in_range;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_merged;
  logic              rd_in_range;
  logic              coll;

  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              s0_uninit;
  logic              s0_err;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;
  assign wr_ok       = wr_enb && wr_in_range && (|wr_be);
  assign coll        = wr_ok && rd_enb && (wr_addr == rd_addr);

  assign wr_merged = DATA_W'(be_merge(MAX_DATA_W'(mem[wr_addr]), MAX_DATA_W'(wr_data),
                                      MAX_BE_W'(wr_be), init_q[wr_addr]));

  // Array contents survive reset; only the init bitmap decides what is readable.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_addr] <= wr_merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_enb && !wr_in_range;
      if (wr_ok)
        init_q[wr_addr] <= 1'b1;
    end
  end

  // Write-first collisions bypass the array with the merged word; the post-write
  // init bit is always 1 there because wr_ok requires a non-zero byte enable.
  always_comb begin
    s0_valid  = rd_enb;
    s0_data   = '0;
    s0_uninit = 1'b0;
    s0_err    = 1'b0;
    if (!rd_in_range)
      s0_err = 1'b1;
    else if (coll && COLL_MODE == WRITE_FIRST)
      s0_data = wr_merged;
    else if (init_q[rd_addr])
      s0_data = mem[rd_addr];
    else
      s0_uninit = 1'b1;
  end

  ram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .s0_valid  (s0_valid),
    .s0_data   (s0_data),
    .s0_uninit (s0_uninit),
    .s0_err    (s0_err),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_uninit (rd_uninit),
    .rd_err    (rd_err)
  );

  a_wr_addr_known: assert property (@(posedge clk) disable iff (!rst)
    wr_enb |-> !$isunknown(wr_addr));
  a_rd_addr_known: assert property (@(posedge clk) disable iff (!rst)
    rd_enb |-> !$isunknown(rd_addr));

endmodule

// File: tb/tb_ram_dp_param.sv
// Scoreboard bench: two RAM instances (write-first/RD_LAT=3, read-first/RD_LAT=2)
// share one directed stimulus stream; expected read results are queued per instance.
module tb_ram_dp_param;
  import ram_pkg::*;

  localparam int DW     = 16;
  localparam int AW     = 4;
  localparam int DEP    = 12;
  localparam int LAT_WF = 3;
  localparam int LAT_RF = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic          uninit;
    logic          err;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_enb = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0]    wr_be = '0;
  logic          rd_enb = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic [DW-1:0] wf_data, rf_data;
  logic          wf_valid, rf_valid, wf_uninit, rf_uninit;
  logic          wf_rerr, rf_rerr, wf_werr, rf_werr;

  exp_t          q_wf[$];
  exp_t          q_rf[$];
  logic [DW-1:0] last_d [2];
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;

  ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT_WF),
                 .COLL_MODE(WRITE_FIRST)) dut_wf (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(wf_data),
    .rd_valid(wf_valid), .rd_uninit(wf_uninit), .rd_err(wf_rerr), .wr_err(wf_werr));

  ram_dp_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(LAT_RF),
                 .COLL_MODE(READ_FIRST)) dut_rf (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rf_data),
    .rd_valid(rf_valid), .rd_uninit(rf_uninit), .rd_err(rf_rerr), .wr_err(rf_werr));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Inputs are driven at the negedge; the bench then waits one full cycle.
  task automatic apply_stimulus(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic [1:0] wbe, input logic r, input logic [AW-1:0] ra,
                                input logic [DW-1:0] d_wf, input logic u_wf,
                                input logic [DW-1:0] d_rf, input logic u_rf,
                                input logic e, input bit track);
    exp_t ex;
    wr_enb = w; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_enb = r; rd_addr = ra;
    if (r && track) begin
      ex = '{data: d_wf, uninit: u_wf, err: e, due: cyc + LAT_WF};
      q_wf.push_back(ex);
      ex = '{data: d_rf, uninit: u_rf, err: e, due: cyc + LAT_RF};
      q_rf.push_back(ex);
    end
    @(negedge clk);
    wr_enb = 1'b0;
    rd_enb = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [1:0] be);
    apply_stimulus(1'b1, AW'(a), d, be, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_read(input int a, input logic [DW-1:0] d, input logic u, input logic e);
    apply_stimulus(1'b0, '0, '0, 2'b00, 1'b1, AW'(a), d, u, d, u, e, 1'b1);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic monitor(input bit rf);
    logic v, u, e, we;
    logic [DW-1:0] d;
    exp_t ex;
    string who;
    int pending;
    who = rf ? "rf" : "wf";
    v  = rf ? rf_valid  : wf_valid;
    d  = rf ? rf_data   : wf_data;
    u  = rf ? rf_uninit : wf_uninit;
    e  = rf ? rf_rerr   : wf_rerr;
    we = rf ? rf_werr   : wf_werr;
    pending = rf ? q_rf.size() : q_wf.size();
    if (!rst) begin
      check_output({who, " reset rd_valid"}, 32'(v), 0);
      check_output({who, " reset rd_data"}, 32'(d), 0);
      check_output({who, " reset rd_uninit"}, 32'(u), 0);
      check_output({who, " reset rd_err"}, 32'(e), 0);
      check_output({who, " reset wr_err"}, 32'(we), 0);
      last_d[rf] = '0;
    end else if (v) begin
      if (pending == 0) begin
        check_output({who, " rd_valid with no pending read"}, 32'(v), 0);
      end else begin
        ex = rf ? q_rf.pop_front() : q_wf.pop_front();
        check_output({who, " rd_data"}, 32'(d), 32'(ex.data));
        check_output({who, " rd_uninit"}, 32'(u), 32'(ex.uninit));
        check_output({who, " rd_err"}, 32'(e), 32'(ex.err));
        check_output({who, " read latency cycle"}, cyc, ex.due);
        last_d[rf] = ex.data;
      end
    end else begin
      check_output({who, " idle rd_data hold"}, 32'(d), 32'(last_d[rf]));
      check_output({who, " idle rd_uninit"}, 32'(u), 0);
      check_output({who, " idle rd_err"}, 32'(e), 0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    monitor(1'b0);
    monitor(1'b1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Fresh entry after reset reads as uninitialised zero.
    do_read(3, 16'h0000, 1'b1, 1'b0);

    // Byte-enable merging, including zero-fill of a fresh entry.
    do_write(5, 16'h1234, 2'b11);
    do_write(5, 16'hAB00, 2'b10);
    do_read(5, 16'hAB34, 1'b0, 1'b0);
    do_write(6, 16'hBEEF, 2'b01);
    do_read(6, 16'h00EF, 1'b0, 1'b0);

    // Back-to-back reads return in order, one per cycle.
    for (int i = 0; i < 4; i++) do_write(i, DW'(16'h0010 + i), 2'b11);
    for (int i = 0; i < 4; i++) do_read(i, DW'(16'h0010 + i), 1'b0, 1'b0);

    // Same-edge collisions: initialised full-word, then fresh partial-word.
    do_write(7, 16'h0055, 2'b11);
    apply_stimulus(1'b1, 4'd7, 16'h00AA, 2'b11, 1'b1, 4'd7,
                   16'h00AA, 1'b0, 16'h0055, 1'b0, 1'b0, 1'b1);
    do_read(7, 16'h00AA, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd8, 16'h1234, 2'b01, 1'b1, 4'd8,
                   16'h0034, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    do_read(8, 16'h0034, 1'b0, 1'b0);

    // Zero byte-enable write leaves the entry uninitialised.
    do_write(9, 16'h5A5A, 2'b00);
    do_read(9, 16'h0000, 1'b1, 1'b0);

    // Out-of-range writes pulse wr_err for one cycle and do not alias.
    do_write(13, 16'hFFFF, 2'b11);
    check_output("wf wr_err pulse", 32'(wf_werr), 1);
    check_output("rf wr_err pulse", 32'(rf_werr), 1);
    idle();
    check_output("wf wr_err cleared", 32'(wf_werr), 0);
    check_output("rf wr_err cleared", 32'(rf_werr), 0);
    do_write(12, 16'h1111, 2'b11);
    check_output("wf wr_err at DEPTH", 32'(wf_werr), 1);
    check_output("rf wr_err at DEPTH", 32'(rf_werr), 1);
    do_read(13, 16'h0000, 1'b0, 1'b1);
    do_read(12, 16'h0000, 1'b0, 1'b1);
    do_read(1, 16'h0011, 1'b0, 1'b0);
    do_read(11, 16'h0000, 1'b1, 1'b0);
    do_write(11, 16'hCAFE, 2'b11);
    do_read(11, 16'hCAFE, 1'b0, 1'b0);
    repeat (5) idle();

    // Reset with a read in flight: it must never surface.
    do_write(2, 16'h0077, 2'b11);
    apply_stimulus(1'b0, '0, '0, 2'b00, 1'b1, 4'd2, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    q_wf.delete();
    q_rf.delete();
    #1;
    check_output("wf async reset rd_data", 32'(wf_data), 0);
    check_output("rf async reset rd_data", 32'(rf_data), 0);
    check_output("wf async reset rd_valid", 32'(wf_valid), 0);
    check_output("rf async reset rd_valid", 32'(rf_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) idle();
    do_read(2, 16'h0000, 1'b1, 1'b0);
    do_read(5, 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 20 && (q_wf.size() != 0 || q_rf.size() != 0); i++) @(negedge clk);
    check_output("all queued reads returned", 32'(q_wf.size() + q_rf.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
